// File: rtl/versa_rp_multi.sv
// -----------------------------------------------------------------------------
// versa_rp_multi
//
// Hardware guard that watches the CPU program counter and the CPU/DMA bus and
// forces a CPU reset when the protected-execution rules are broken. A small
// three-state machine (LOCK / UNLOCK / RESET) tracks whether the authorised
// handler has opened access to the peripheral windows.
//
// Optional feature: define VERSA_RP_CAUSE_EN to add the viol_cause output,
// which records the condition code (1..6) of the last counted violation.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   pc         in   current program counter (AW)
//   data_addr  in   CPU data address (AW)
//   data_en    in   CPU data access enable
//   data_wr    in   CPU data write strobe
//   dma_addr   in   DMA address (AW)
//   dma_en     in   DMA access enable
//   ER_min     in   executable region lower bound, inclusive (AW)
//   ER_max     in   executable region upper bound, inclusive (AW)
//   win_en     in   per-window runtime protect enable (NWIN)
//   reset      out  registered reset request to the CPU
//   state_o    out  current state: 00 LOCK, 01 UNLOCK, 10 RESET
//   viol_cnt   out  saturating count of violations taken from LOCK/UNLOCK
//   viol_cause out  (VERSA_RP_CAUSE_EN only) code of last counted violation
// -----------------------------------------------------------------------------
module versa_rp_multi #(
  parameter int                 AW            = 16,
  parameter int                 NWIN          = 2,
  parameter logic [NWIN*AW-1:0] WIN_BASE      = {16'h0038, 16'h0018},
  parameter logic [NWIN*AW-1:0] WIN_SIZE      = {16'h0008, 16'h0020},
  parameter logic [AW-1:0]      SMEM_BASE     = 16'hA000,
  parameter logic [AW-1:0]      SMEM_SIZE     = 16'h4000,
  parameter logic [AW-1:0]      META_MIN      = 16'h0140,
  parameter logic [AW-1:0]      META_SIZE     = 16'h0004,
  parameter logic [AW-1:0]      AUTH_HANDLER  = 16'hA0BE,
  parameter logic [AW-1:0]      RESET_HANDLER = 16'h0000,
  parameter int                 HOLD_CYC      = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   pc,
  input  logic [AW-1:0]   data_addr,
  input  logic            data_en,
  input  logic            data_wr,
  input  logic [AW-1:0]   dma_addr,
  input  logic            dma_en,
  input  logic [AW-1:0]   ER_min,
  input  logic [AW-1:0]   ER_max,
  input  logic [NWIN-1:0] win_en,
  output logic            reset,
  output logic [1:0]      state_o,
  output logic [7:0]      viol_cnt
`ifdef VERSA_RP_CAUSE_EN
  ,
  output logic [2:0]      viol_cause
`endif
);

  typedef enum logic [1:0] {
    ST_LOCK   = 2'b00,
    ST_UNLOCK = 2'b01,
    ST_RESET  = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYC);

  // Secure memory occupies SMEM_SIZE bytes starting at SMEM_BASE; the end
  // address is exclusive so an ER starting right after it is legal.
  localparam logic [AW:0] SMEM_END = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};

  // Metadata write protection covers [META_MIN, META_MIN+META_SIZE-2]; the
  // last metadata byte stays writable.
  localparam logic        META_ON  = (META_SIZE >= AW'(2));
  localparam logic [AW:0] META_LIM = {1'b0, META_MIN} + {1'b0, META_SIZE}
                                     - (AW+1)'(2);

  // ---------------------------------------------------------------------------
  // Address classification helpers
  // ---------------------------------------------------------------------------
  // Window limit is computed one bit wider so a window ending at the top of
  // the address space does not wrap to a small value.
  function automatic logic win_hit(input logic [AW-1:0]   a,
                                   input logic [NWIN-1:0] en);
    logic          hit;
    logic [AW-1:0] b;
    logic [AW-1:0] s;
    logic [AW:0]   lim;
    hit = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      b   = WIN_BASE[i*AW +: AW];
      s   = WIN_SIZE[i*AW +: AW];
      lim = {1'b0, b} + {1'b0, s} - (AW+1)'(1);
      if (en[i] && (s != '0) && (a >= b) && ({1'b0, a} <= lim)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic logic prot_hit(input logic [AW-1:0] a,
                                    input logic [AW-1:0] er_lo,
                                    input logic [AW-1:0] er_hi);
    logic in_meta;
    logic in_er;
    in_meta = META_ON && (a >= META_MIN) && ({1'b0, a} <= META_LIM);
    in_er   = (a >= er_lo) && (a <= er_hi);
    return in_meta || in_er;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic       reset_q;
  logic [7:0] hold_q, hold_d;
  logic [7:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Condition evaluation
  // ---------------------------------------------------------------------------
  logic       rd_win;
  logic       wr_prot;
  logic       bad_er;
  logic       pc_in_er;
  logic       pc_auth;
  logic       pc_rst;
  logic [2:0] cause_code;
  logic       viol;

  always_comb begin
    rd_win   = (data_en && win_hit(data_addr, win_en)) ||
               (dma_en  && win_hit(dma_addr,  win_en));
    // Each bus contributes its own address: the CPU only when writing, the
    // DMA on any access.
    wr_prot  = (data_wr && prot_hit(data_addr, ER_min, ER_max)) ||
               (dma_en  && prot_hit(dma_addr,  ER_min, ER_max));
    bad_er   = (ER_min >= ER_max) ||
               (({1'b0, ER_min} < SMEM_END) && (ER_max >= SMEM_BASE)) ||
               (ER_min == RESET_HANDLER) || (ER_max == RESET_HANDLER);
    pc_in_er = (pc >= ER_min) && (pc < ER_max);
    pc_auth  = (pc == AUTH_HANDLER);
    pc_rst   = (pc == RESET_HANDLER);
  end

  // Priority encoder: lowest condition number wins. 0 means no violation.
  always_comb begin
    cause_code = 3'd0;
    if (bad_er) begin
      cause_code = 3'd1;
    end else if (pc_auth && wr_prot) begin
      cause_code = 3'd2;
    end else if ((state_q == ST_LOCK) && rd_win) begin
      cause_code = 3'd3;
    end else if ((state_q == ST_UNLOCK) && pc_rst) begin
      cause_code = 3'd4;
    end else if ((state_q == ST_UNLOCK) && rd_win && !pc_in_er) begin
      cause_code = 3'd5;
    end else if ((state_q == ST_UNLOCK) && rd_win && wr_prot) begin
      cause_code = 3'd6;
    end
    viol = (cause_code != 3'd0);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (viol) begin
      state_d = ST_RESET;
      hold_d  = HOLD_INIT;
      // Violations raised while already resetting only extend the hold.
      if ((state_q != ST_RESET) && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        ST_RESET: begin
          if (pc_rst && !rd_win && (hold_q == 8'd0)) begin
            state_d = ST_LOCK;
          end
          if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
          end
        end
        ST_LOCK: begin
          if (pc_auth && !wr_prot && !rd_win) begin
            state_d = ST_UNLOCK;
          end
        end
        ST_UNLOCK: begin
          if ((pc == ER_max) || wr_prot) begin
            state_d = ST_LOCK;
          end
        end
        default: begin
          state_d = ST_RESET;
          hold_d  = HOLD_INIT;
        end
      endcase
    end
  end

  // Reset output is registered from the next state so a violation seen in
  // cycle n asserts reset in cycle n+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RESET;
      reset_q <= 1'b1;
      hold_q  <= HOLD_INIT;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      reset_q <= (state_d == ST_RESET);
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef VERSA_RP_CAUSE_EN
  logic [2:0] cause_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= 3'd0;
    end else if (viol && (state_q != ST_RESET)) begin
      cause_q <= cause_code;
    end
  end

  assign viol_cause = cause_q;
`else
  // Without the cause register the condition code only feeds the violation
  // flag.
`endif

  assign reset    = reset_q;
  assign state_o  = state_q;
  assign viol_cnt = cnt_q;

endmodule

// File: tb/tb_versa_rp_multi.sv
// -----------------------------------------------------------------------------
// tb_versa_rp_multi
//
// Directed bench for versa_rp_multi with default parameters. Windows:
// win0 = [0x0018,0x0037], win1 = [0x0038,0x003F]; metadata write guard
// [0x0140,0x0142]; ER is [0xE000,0xE100] unless a step changes it.
// -----------------------------------------------------------------------------
module tb_versa_rp_multi;

  localparam logic [1:0] S_LOCK   = 2'b00;
  localparam logic [1:0] S_UNLOCK = 2'b01;
  localparam logic [1:0] S_RESET  = 2'b10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic [15:0] data_addr;
  logic        data_en;
  logic        data_wr;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic [15:0] ER_min;
  logic [15:0] ER_max;
  logic [1:0]  win_en;
  logic        reset;
  logic [1:0]  state_o;
  logic [7:0]  viol_cnt;
`ifdef VERSA_RP_CAUSE_EN
  logic [2:0]  viol_cause;
`endif

  always #5 clk = ~clk;

  versa_rp_multi dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .data_addr  (data_addr),
    .data_en    (data_en),
    .data_wr    (data_wr),
    .dma_addr   (dma_addr),
    .dma_en     (dma_en),
    .ER_min     (ER_min),
    .ER_max     (ER_max),
    .win_en     (win_en),
    .reset      (reset),
    .state_o    (state_o),
    .viol_cnt   (viol_cnt)
`ifdef VERSA_RP_CAUSE_EN
    ,
    .viol_cause (viol_cause)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cause(input string tag, input logic [2:0] exp);
`ifdef VERSA_RP_CAUSE_EN
    check(tag, {29'd0, viol_cause}, {29'd0, exp});
`else
    if (exp == 3'd7) $display("cause %s unused", tag);
`endif
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // With pc at the reset handler, RESET takes HOLD_CYC decrement edges plus
  // one transition edge to reach LOCK.
  task automatic recover(input string tag);
    pc        = 16'h0000;
    data_en   = 1'b0;
    data_wr   = 1'b0;
    dma_en    = 1'b0;
    repeat (5) step();
    check(tag, {30'd0, state_o}, {30'd0, S_LOCK});
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset_n   = 1'b0;
    pc        = 16'h0000;
    data_addr = 16'h0000;
    data_en   = 1'b0;
    data_wr   = 1'b0;
    dma_addr  = 16'h0000;
    dma_en    = 1'b0;
    ER_min    = 16'hE000;
    ER_max    = 16'hE100;
    win_en    = 2'b11;

    // Reset values
    step();
    step();
    check("rst_state", {30'd0, state_o}, {30'd0, S_RESET});
    check("rst_reset", {31'd0, reset}, 32'd1);
    check("rst_cnt",   {24'd0, viol_cnt}, 32'd0);
    check_cause("rst_cause", 3'd0);

    // Release: reset held for four cycles, then LOCK
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_reset", {31'd0, reset}, 32'd1);
    end
    step();
    check("boot_lock",  {30'd0, state_o}, {30'd0, S_LOCK});
    check("boot_reset", {31'd0, reset}, 32'd0);

    // LOCK read of window 0 -> C3
    data_en   = 1'b1;
    data_addr = 16'h0020;
    step();
    check("c3_reset", {31'd0, reset}, 32'd1);
    check("c3_cnt",   {24'd0, viol_cnt}, 32'd1);
    check_cause("c3_cause", 3'd3);
    recover("c3_recover");

    // Authorised entry, legal window read inside ER, exit at ER_max
    pc = 16'hA0BE;
    step();
    check("auth_unlock", {30'd0, state_o}, {30'd0, S_UNLOCK});
    pc        = 16'hE050;
    data_en   = 1'b1;
    data_addr = 16'h003A;
    step();
    check("er_read_state", {30'd0, state_o}, {30'd0, S_UNLOCK});
    check("er_read_cnt",   {24'd0, viol_cnt}, 32'd1);
    pc      = 16'hE100;
    data_en = 1'b0;
    step();
    check("er_exit_lock", {30'd0, state_o}, {30'd0, S_LOCK});

    // UNLOCK read from outside ER -> C5
    pc = 16'hA0BE;
    step();
    check("auth2_unlock", {30'd0, state_o}, {30'd0, S_UNLOCK});
    pc        = 16'hD000;
    data_en   = 1'b1;
    data_addr = 16'h0018;
    step();
    check("c5_state", {30'd0, state_o}, {30'd0, S_RESET});
    check("c5_cnt",   {24'd0, viol_cnt}, 32'd2);
    check_cause("c5_cause", 3'd5);
    recover("c5_recover");

    // Same access with protection disabled -> no violation
    pc = 16'hA0BE;
    step();
    win_en    = 2'b00;
    pc        = 16'hD000;
    data_en   = 1'b1;
    data_addr = 16'h0018;
    step();
    check("wdis_state", {30'd0, state_o}, {30'd0, S_UNLOCK});
    check("wdis_cnt",   {24'd0, viol_cnt}, 32'd2);
    check("wdis_reset", {31'd0, reset}, 32'd0);
    win_en = 2'b11;

    // Metadata guard boundary: 0x143 free, 0x142 protected (exits UNLOCK)
    data_en   = 1'b0;
    pc        = 16'hE050;
    data_wr   = 1'b1;
    data_addr = 16'h0143;
    step();
    check("meta_top_free", {30'd0, state_o}, {30'd0, S_UNLOCK});
    data_addr = 16'h0142;
    step();
    check("meta_wr_lock", {30'd0, state_o}, {30'd0, S_LOCK});

    // Authorised handler writing into ER -> C2
    pc        = 16'hA0BE;
    data_wr   = 1'b1;
    data_addr = 16'hE010;
    step();
    check("c2_state", {30'd0, state_o}, {30'd0, S_RESET});
    check("c2_cnt",   {24'd0, viol_cnt}, 32'd3);
    check_cause("c2_cause", 3'd2);
    recover("c2_recover");

    // Jump to reset handler while UNLOCK -> C4
    pc = 16'hA0BE;
    step();
    pc = 16'h0000;
    step();
    check("c4_state", {30'd0, state_o}, {30'd0, S_RESET});
    check("c4_cnt",   {24'd0, viol_cnt}, 32'd4);
    check_cause("c4_cause", 3'd4);
    recover("c4_recover");

    // Window edges in LOCK: 0x17 and 0x40 outside, 0x3F inside
    data_en   = 1'b1;
    data_addr = 16'h0017;
    step();
    check("win_below", {24'd0, viol_cnt}, 32'd4);
    data_addr = 16'h0040;
    step();
    check("win_above", {24'd0, viol_cnt}, 32'd4);
    data_addr = 16'h003F;
    step();
    check("win_top_cnt", {24'd0, viol_cnt}, 32'd5);
    check("win_top_rst", {31'd0, reset}, 32'd1);
    recover("wtop_recover");

    // DMA read of last byte of window 0
    dma_en   = 1'b1;
    dma_addr = 16'h0037;
    step();
    check("dma_cnt", {24'd0, viol_cnt}, 32'd6);
    check_cause("dma_cause", 3'd3);
    recover("dma_recover");

    // UNLOCK window read while DMA writes ER -> C6
    pc = 16'hA0BE;
    step();
    pc        = 16'hE050;
    data_en   = 1'b1;
    data_addr = 16'h0020;
    dma_en    = 1'b1;
    dma_addr  = 16'hE080;
    step();
    check("c6_cnt", {24'd0, viol_cnt}, 32'd7);
    check_cause("c6_cause", 3'd6);
    recover("c6_recover");

    // ER overlapping secure memory -> C1 every cycle, counted once
    ER_min = 16'h9000;
    ER_max = 16'hB000;
    step();
    check("c1_cnt", {24'd0, viol_cnt}, 32'd8);
    check_cause("c1_cause", 3'd1);
    repeat (6) step();
    check("c1_stuck", {30'd0, state_o}, {30'd0, S_RESET});
    check("c1_once",  {24'd0, viol_cnt}, 32'd8);
    ER_min = 16'hE000;
    ER_max = 16'hE100;
    recover("c1_recover");

    // Degenerate ER (min == max) is also rejected
    ER_min = 16'hE100;
    step();
    check("er_eq_cnt", {24'd0, viol_cnt}, 32'd9);
    ER_min = 16'hE000;
    recover("er_eq_recover");

    // 256 forced violations saturate the counter
    for (int i = 0; i < 256; i++) begin
      data_en   = 1'b1;
      data_addr = 16'h0020;
      step();
      recover("sat_loop");
    end
    check("sat_cnt", {24'd0, viol_cnt}, 32'd255);

    // Asynchronous reset mid-UNLOCK overrides everything immediately
    pc = 16'hA0BE;
    step();
    check("pre_arst", {30'd0, state_o}, {30'd0, S_UNLOCK});
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_state", {30'd0, state_o}, {30'd0, S_RESET});
    check("arst_reset", {31'd0, reset}, 32'd1);
    check("arst_cnt",   {24'd0, viol_cnt}, 32'd0);
    step();
    check("arst_held", {30'd0, state_o}, {30'd0, S_RESET});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
